ex_stage: RTL and testbench

Execute stage of the 5-stage pipeline, directly downstream of the ID/EX pipeline register. It consumes the ID/EX operands and control, resolves data hazards by forwarding from EX/MEM and MEM/WB, and decodes ALU control. It computes the result, including an optional iterative 32-cycle multiplier that stalls the front end, and registers everything into the EX/MEM pipeline register it owns.

---
 rtl/ex_stage_pkg.sv | 66 ++++++
 rtl/ex_stage_if.sv | 33 +++
 rtl/ex_mul_seq.sv | 55 +++++
 rtl/ex_stage.sv | 143 ++++++++++++++
 tb/tb_ex_stage.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALUOp/funct encodings, ALU control,
// forwarding selects, multiplier FSM states. EX_MUL_EN enables funct 0x18 (MUL).
package ex_stage_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL, ALU_ZERO
    } aluCtl_e;

    typedef enum logic [1:0] {
        FWD_IDEX, FWD_EXMEM, FWD_MEMWB
    } fwdSel_e;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    function automatic aluCtl_e aluDecode(input logic [1:0] aluOp, input logic [5:0] funct);
        aluCtl_e ctl;
        ctl = ALU_ZERO;
        case (aluOp)
            ALUOP_ADD: ctl = ALU_ADD;
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_OR:  ctl = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctl = ALU_ADD;
                    FUNCT_SUB: ctl = ALU_SUB;
                    FUNCT_AND: ctl = ALU_AND;
                    FUNCT_OR:  ctl = ALU_OR;
                    FUNCT_SLT: ctl = ALU_SLT;
`ifdef EX_MUL_EN
                    FUNCT_MUL: ctl = ALU_MUL;
`else
                    // Without the multiplier MUL is just another unknown funct.
                    FUNCT_MUL: ctl = ALU_ZERO;
`endif
                    default:   ctl = ALU_ZERO;
                endcase
            end
            default: ctl = ALU_ZERO;
        endcase
        return ctl;
    endfunction

    // EX/MEM wins over MEM/WB because it holds the younger result; r0 never forwards.
    function automatic fwdSel_e fwdSelect(input logic [4:0] idx,
                                          input logic exWe, input logic [4:0] exRd,
                                          input logic wbWe, input logic [4:0] wbRd);
        if (exWe && exRd != 5'd0 && exRd == idx) return FWD_EXMEM;
        if (wbWe && wbRd != 5'd0 && wbRd == idx) return FWD_MEMWB;
        return FWD_IDEX;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX + MEM/WB inputs and EX/MEM outputs of the execute stage.
// master = pipeline side driving ID/EX, slave = ex_stage.
interface ex_stage_if;
    logic [31:0] regA_i, regB_i, immidiate_i;
    logic [1:0]  ALUOp_i;
    logic        RegDst_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i;
    logic [4:0]  RegistersRS_i, RegistersRT_i, RegistersRD_i;
    logic        WB_RegWrite_i;
    logic [4:0]  WB_RegRD_i;
    logic [31:0] WB_data_i;
    logic [31:0] ALUResult_o, WriteData_o;
    logic [4:0]  RegRD_o;
    logic        RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o;
    logic        stall_o;

    modport master (
        output regA_i, regB_i, immidiate_i, ALUOp_i,
               RegDst_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i,
               RegistersRS_i, RegistersRT_i, RegistersRD_i,
               WB_RegWrite_i, WB_RegRD_i, WB_data_i,
        input  ALUResult_o, WriteData_o, RegRD_o,
               RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o, stall_o
    );

    modport slave (
        input  regA_i, regB_i, immidiate_i, ALUOp_i,
               RegDst_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i,
               RegistersRS_i, RegistersRT_i, RegistersRD_i,
               WB_RegWrite_i, WB_RegRD_i, WB_data_i,
        output ALUResult_o, WriteData_o, RegRD_o,
               RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o, stall_o
    );
endinterface

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: IDLE -> BUSY (32 steps) -> DONE.
// Only instantiated when EX_MUL_EN is defined; low 32 bits of the product are used.
module ex_mul_seq
    import ex_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] mcand, acc;
    logic [31:0] mplier;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= MUL_IDLE;
            cnt    <= 5'd0;
            mcand  <= 64'd0;
            acc    <= 64'd0;
            mplier <= 32'd0;
        end else begin
            case (state)
                MUL_IDLE: if (start_i) begin
                    mcand  <= {32'd0, a_i};
                    mplier <= b_i;
                    acc    <= 64'd0;
                    cnt    <= 5'd0;
                    state  <= MUL_BUSY;
                end
                MUL_BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= MUL_DONE;
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    assign busy_o    = (state == MUL_BUSY);
    assign done_o    = (state == MUL_DONE);
    assign product_o = acc[31:0];

    logic unusedAccHi;
    assign unusedAccHi = ^acc[63:32];
endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, EX/MEM register. With EX_MUL_EN defined a
// 32-cycle iterative MUL stalls the front end; otherwise stall_o is tied low.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    ex_stage_if.slave   bus
);
    logic [31:0] exRes, exWData;
    logic [4:0]  exRd;
    logic        exRegWrite, exMemtoReg, exMemWrite, exMemRead;

    fwdSel_e     selA, selB;
    aluCtl_e     aluCtl;
    logic [31:0] opA, fwdB, aluB, aluRes;
    logic [4:0]  destRd;
    logic        stall;

    assign selA = fwdSelect(bus.RegistersRS_i, exRegWrite, exRd, bus.WB_RegWrite_i, bus.WB_RegRD_i);
    assign selB = fwdSelect(bus.RegistersRT_i, exRegWrite, exRd, bus.WB_RegWrite_i, bus.WB_RegRD_i);

    always_comb begin
        opA = bus.regA_i;
        case (selA)
            FWD_EXMEM: opA = exRes;
            FWD_MEMWB: opA = bus.WB_data_i;
            default: ;
        endcase
    end

    always_comb begin
        fwdB = bus.regB_i;
        case (selB)
            FWD_EXMEM: fwdB = exRes;
            FWD_MEMWB: fwdB = bus.WB_data_i;
            default: ;
        endcase
    end

    assign aluB   = bus.ALUSrc_i ? bus.immidiate_i : fwdB;
    assign destRd = bus.RegDst_i ? bus.RegistersRD_i : bus.RegistersRT_i;
    assign aluCtl = aluDecode(bus.ALUOp_i, bus.immidiate_i[5:0]);

    always_comb begin
        aluRes = 32'd0;
        case (aluCtl)
            ALU_ADD: aluRes = opA + aluB;
            ALU_SUB: aluRes = opA - aluB;
            ALU_AND: aluRes = opA & aluB;
            ALU_OR:  aluRes = opA | aluB;
            ALU_SLT: aluRes = {31'd0, $signed(opA) < $signed(aluB)};
            default: aluRes = 32'd0;
        endcase
    end

`ifdef EX_MUL_EN
    logic        mulBusy, mulDone, mulStart;
    logic [31:0] mulProd;
    logic [4:0]  capRd;
    logic        capRegWrite, capMemtoReg, capMemWrite, capMemRead;

    assign mulStart = !mulBusy && !mulDone && (aluCtl == ALU_MUL);
    // Held low during reset so an aborted multiply releases the front end at once.
    assign stall    = !rst_i && (mulStart || mulBusy);

    ex_mul_seq uMul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mulStart),
        .a_i       (opA),
        .b_i       (fwdB),
        .busy_o    (mulBusy),
        .done_o    (mulDone),
        .product_o (mulProd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            capRd       <= 5'd0;
            capRegWrite <= 1'b0;
            capMemtoReg <= 1'b0;
            capMemWrite <= 1'b0;
            capMemRead  <= 1'b0;
        end else if (mulStart) begin
            capRd       <= destRd;
            capRegWrite <= bus.RegWrite_i;
            capMemtoReg <= bus.MemtoReg_i;
            capMemWrite <= bus.MemWrite_i;
            capMemRead  <= bus.MemRead_i;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exRes      <= 32'd0;
            exWData    <= 32'd0;
            exRd       <= 5'd0;
            exRegWrite <= 1'b0;
            exMemtoReg <= 1'b0;
            exMemWrite <= 1'b0;
            exMemRead  <= 1'b0;
`ifdef EX_MUL_EN
        end else if (mulDone) begin
            exRes      <= mulProd;
            exWData    <= 32'd0;
            exRd       <= capRd;
            exRegWrite <= capRegWrite;
            exMemtoReg <= capMemtoReg;
            exMemWrite <= capMemWrite;
            exMemRead  <= capMemRead;
`endif
        end else if (stall) begin
            exRes      <= 32'd0;
            exWData    <= 32'd0;
            exRd       <= 5'd0;
            exRegWrite <= 1'b0;
            exMemtoReg <= 1'b0;
            exMemWrite <= 1'b0;
            exMemRead  <= 1'b0;
        end else begin
            exRes      <= aluRes;
            exWData    <= fwdB;
            exRd       <= destRd;
            exRegWrite <= bus.RegWrite_i;
            exMemtoReg <= bus.MemtoReg_i;
            exMemWrite <= bus.MemWrite_i;
            exMemRead  <= bus.MemRead_i;
        end
    end

    assign bus.ALUResult_o = exRes;
    assign bus.WriteData_o = exWData;
    assign bus.RegRD_o     = exRd;
    assign bus.RegWrite_o  = exRegWrite;
    assign bus.MemtoReg_o  = exMemtoReg;
    assign bus.MemWrite_o  = exMemWrite;
    assign bus.MemRead_o   = exMemRead;
    assign bus.stall_o     = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; MUL vectors are selected by EX_MUL_EN.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_stage_if bus();
    ex_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // {RegDst, ALUSrc, RegWrite, MemtoReg, MemWrite, MemRead}
    localparam logic [5:0] C_R   = 6'b101000;
    localparam logic [5:0] C_I   = 6'b001000;
    localparam logic [5:0] C_LW  = 6'b011101;
    localparam logic [5:0] C_SW  = 6'b010010;
    localparam logic [5:0] C_NOP = 6'b000000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idex(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] ctl);
        bus.ALUOp_i       = op;
        bus.regA_i        = a;
        bus.regB_i        = b;
        bus.immidiate_i   = imm;
        bus.RegistersRS_i = rs;
        bus.RegistersRT_i = rt;
        bus.RegistersRD_i = rd;
        {bus.RegDst_i, bus.ALUSrc_i, bus.RegWrite_i,
         bus.MemtoReg_i, bus.MemWrite_i, bus.MemRead_i} = ctl;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.WB_RegWrite_i = we;
        bus.WB_RegRD_i    = rd;
        bus.WB_data_i     = d;
    endtask

    task automatic exOut(input string tag, input logic [31:0] res, input logic [4:0] rd, input logic we);
        chk({tag, ".res"}, bus.ALUResult_o, res);
        chk({tag, ".rd"},  32'(bus.RegRD_o), 32'(rd));
        chk({tag, ".we"},  32'(bus.RegWrite_o), 32'(we));
    endtask

    initial begin
        int n;
        idex(2'b00, 0, 0, 0, 0, 0, 0, C_NOP);
        wb(1'b0, 5'd0, 32'd0);
        #1 rst = 1'b1;
        #1;
        exOut("reset", 32'd0, 5'd0, 1'b0);
        chk("reset.wdata", bus.WriteData_o, 32'd0);
        chk("reset.stall", 32'(bus.stall_o), 32'd0);
        repeat (2) tick;
        @(negedge clk) rst = 1'b0;

        // r3 = 2 + 3
        idex(2'b10, 32'd2, 32'd3, 32'h20, 5'd1, 5'd2, 5'd3, C_R);
        #1 chk("add.stall", 32'(bus.stall_o), 32'd0);
        tick; exOut("add", 32'd5, 5'd3, 1'b1);
        // r4 = r3 + r2, stale regA, EX/MEM forward of 5
        idex(2'b10, 32'd0, 32'd7, 32'h20, 5'd3, 5'd2, 5'd4, C_R);
        tick; exOut("fwdEx", 32'd12, 5'd4, 1'b1);
        idex(2'b10, 32'd2, 32'd3, 32'h20, 5'd1, 5'd2, 5'd3, C_R);
        tick; exOut("add2", 32'd5, 5'd3, 1'b1);
        // EX/MEM (5) beats MEM/WB (9) for r3
        wb(1'b1, 5'd3, 32'd9);
        idex(2'b10, 32'd0, 32'd0, 32'h20, 5'd3, 5'd0, 5'd5, C_R);
        tick; exOut("prio", 32'd5, 5'd5, 1'b1);
        // A from MEM/WB (9), B from EX/MEM r5 (5)
        idex(2'b10, 32'd1, 32'd0, 32'h20, 5'd3, 5'd5, 5'd6, C_R);
        tick; exOut("fwdWb", 32'd14, 5'd6, 1'b1);
        // write r0 = 9, then r0 must never forward
        wb(1'b0, 5'd0, 32'd0);
        idex(2'b10, 32'd4, 32'd5, 32'h20, 5'd7, 5'd8, 5'd0, C_R);
        tick; exOut("wrR0", 32'd9, 5'd0, 1'b1);
        wb(1'b1, 5'd0, 32'd9);
        idex(2'b10, 32'h11, 32'h22, 32'h20, 5'd0, 5'd0, 5'd9, C_R);
        tick; exOut("r0", 32'h33, 5'd9, 1'b1);
        // lw r8, -4(r10)
        wb(1'b0, 5'd0, 32'd0);
        idex(2'b00, 32'h100, 32'd0, 32'hFFFF_FFFC, 5'd10, 5'd8, 5'd1, C_LW);
        tick; exOut("lw", 32'h0000_00FC, 5'd8, 1'b1);
        chk("lw.memRead", 32'(bus.MemRead_o), 32'd1);
        chk("lw.memtoReg", 32'(bus.MemtoReg_o), 32'd1);
        // sw r8, 4(r11): store data forwarded from the lw slot
        idex(2'b00, 32'h200, 32'hAB, 32'd4, 5'd11, 5'd8, 5'd0, C_SW);
        tick; exOut("sw", 32'h204, 5'd8, 1'b0);
        chk("sw.wdata", bus.WriteData_o, 32'h0000_00FC);
        chk("sw.memWrite", 32'(bus.MemWrite_o), 32'd1);
        idex(2'b10, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd11, 5'd12, 5'd13, C_R);
        tick; exOut("slt", 32'd1, 5'd13, 1'b1);
        idex(2'b01, 32'd5, 32'd5, 32'd0, 5'd14, 5'd15, 5'd0, C_I);
        tick; exOut("sub", 32'd0, 5'd15, 1'b1);
        chk("sub.wdata", bus.WriteData_o, 32'd5);
        idex(2'b10, 32'hF0F0, 32'hFF00, 32'h24, 5'd16, 5'd17, 5'd18, C_R);
        tick; exOut("and", 32'hF000, 5'd18, 1'b1);
        idex(2'b11, 32'h0F, 32'hF0, 32'd0, 5'd19, 5'd20, 5'd0, C_I);
        tick; exOut("or", 32'hFF, 5'd20, 1'b1);
        idex(2'b10, 32'd3, 32'd5, 32'h22, 5'd21, 5'd22, 5'd23, C_R);
        tick; exOut("rsub", 32'hFFFF_FFFE, 5'd23, 1'b1);
        idex(2'b10, 32'd3, 32'd5, 32'h3F, 5'd21, 5'd22, 5'd24, C_R);
        tick; exOut("unk", 32'd0, 5'd24, 1'b1);
        idex(2'b10, 32'hFFFF_FFFF, 32'd2, 32'h20, 5'd25, 5'd26, 5'd27, C_R);
        tick; exOut("wrap", 32'd1, 5'd27, 1'b1);

`ifdef EX_MUL_EN
        // 0x10000 * 0x30004 -> low word 0x00040000; later MEM/WB traffic must not matter
        idex(2'b10, 32'h0001_0000, 32'h0003_0004, 32'h18, 5'd28, 5'd29, 5'd30, C_R);
        #1;
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("mul.stall%0d", i), 32'(bus.stall_o), 32'd1);
            if (i == 5) wb(1'b1, 5'd28, 32'hDEAD);
            tick;
            chk($sformatf("mul.bubble%0d", i), bus.ALUResult_o | 32'(bus.RegWrite_o), 32'd0);
        end
        chk("mul.doneStall", 32'(bus.stall_o), 32'd0);
        tick; exOut("mul", 32'h0004_0000, 5'd30, 1'b1);
        wb(1'b0, 5'd0, 32'd0);
        idex(2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, C_NOP);
        #1 chk("mul.idle", 32'(bus.stall_o), 32'd0);

        // abort in BUSY cycle 10, then 3*7
        idex(2'b10, 32'h1234, 32'h5678, 32'h18, 5'd1, 5'd2, 5'd19, C_R);
        repeat (10) tick;
        #2 rst = 1'b1;
        #1;
        chk("abort.stall", 32'(bus.stall_o), 32'd0);
        exOut("abort", 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        idex(2'b10, 32'd3, 32'd7, 32'h18, 5'd1, 5'd2, 5'd20, C_R);
        rst = 1'b0;
        #1;
        n = 0;
        while (bus.stall_o && n < 40) begin
            tick;
            n++;
        end
        chk("mul2.stallCycles", 32'(n), 32'd33);
        tick; exOut("mul2", 32'd21, 5'd20, 1'b1);
`else
        idex(2'b10, 32'h0001_0000, 32'h0003_0004, 32'h18, 5'd28, 5'd29, 5'd30, C_R);
        #1 chk("mulOff.stall", 32'(bus.stall_o), 32'd0);
        tick; exOut("mulOff", 32'd0, 5'd30, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
